// File: rtl/wb_slave_mux.sv
// N-way Wishbone classic slave mux: registered request/ack FSM with a default word for unmapped accesses.
// Optional ack watchdog and timeout counter are built when WB_MUX_TIMEOUT_EN is defined.
module wb_slave_mux #(
    parameter int          N_SLAVES     = 4,
    parameter int          SEL_LSB      = 14,
    parameter int          SEL_W        = 3,
    parameter int          TIMEOUT      = 255,
    parameter logic [31:0] DEFAULT_DATA = 32'hDEADBEEF
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic [N_SLAVES-1:0]      s_cyc_o,
    output logic [N_SLAVES-1:0]      s_stb_o,
    input  logic [N_SLAVES-1:0]      s_ack_i,
    input  logic [32*N_SLAVES-1:0]   s_dat_i,
    output logic [7:0]               timeout_cnt_o
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    idx_q, idx_d, adr_idx;
    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d;
    logic [N_SLAVES-1:0] stb_q, stb_d;
    logic [N_SLAVES-1:0] sel_mask, adr_mask;
    logic [31:0]         sel_dat;
    logic                sel_ack;
    logic                timeout_hit;
    logic                to_evt;

    assign adr_idx = wbs_adr_i[SEL_LSB +: SEL_W];

    // One-hot decodes built by comparison so no index is wider than its target.
    always_comb begin
        sel_mask = '0;
        adr_mask = '0;
        sel_dat  = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            sel_mask[k] = (idx_q == SEL_W'(k));
            adr_mask[k] = (adr_idx == SEL_W'(k));
            if (sel_mask[k]) sel_dat = s_dat_i[32*k +: 32];
        end
    end

    assign sel_ack = |(s_ack_i & sel_mask);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ack_d   = 1'b0;
        dat_d   = dat_q;
        stb_d   = stb_q;
        to_evt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    idx_d = adr_idx;
                    if (|adr_mask) begin
                        state_d = BUSY;
                        stb_d   = adr_mask;
                    end else begin
                        state_d = RESP;
                        ack_d   = 1'b1;
                        dat_d   = DEFAULT_DATA;
                    end
                end
            end
            BUSY: begin
                // Priority: master abort, then slave ack, then watchdog.
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                    stb_d   = '0;
                end else if (sel_ack) begin
                    state_d = RESP;
                    stb_d   = '0;
                    ack_d   = 1'b1;
                    dat_d   = sel_dat;
                end else if (timeout_hit) begin
                    state_d = RESP;
                    stb_d   = '0;
                    ack_d   = 1'b1;
                    dat_d   = DEFAULT_DATA;
                    to_evt  = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            stb_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            stb_q   <= stb_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign s_cyc_o   = stb_q;
    assign s_stb_o   = stb_q;

`ifdef WB_MUX_TIMEOUT_EN
    logic [7:0] wait_q, tcnt_q;
    logic       unused;

    // wait_q counts completed BUSY cycles; the TIMEOUT-th one ends the transfer.
    assign timeout_hit = (wait_q == 8'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            wait_q <= '0;
            tcnt_q <= '0;
        end else begin
            wait_q <= (state_q == BUSY) ? wait_q + 8'd1 : 8'd0;
            if (to_evt && tcnt_q != 8'hFF) tcnt_q <= tcnt_q + 8'd1;
        end
    end

    assign timeout_cnt_o = tcnt_q;
    assign unused        = ^{wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i};
`else
    logic unused;

    assign timeout_hit   = 1'b0;
    assign timeout_cnt_o = 8'd0;
    assign unused        = ^{wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, to_evt, 8'(TIMEOUT)};
`endif

endmodule

// File: tb/tb_wb_slave_mux.sv
// Randomized bench for wb_slave_mux; each transfer's outcome is predicted from event ordering
// (abort edge, ack edge, watchdog edge) and checked cycle by cycle.
module tb_wb_slave_mux;
    localparam int          N   = 4;
    localparam int          T   = 255;
    localparam logic [31:0] DEF = 32'hDEADBEEF;
    localparam int          NEVER = 1 << 30;
`ifdef WB_MUX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             wb_clk_i = 1'b0;
    logic             wb_rst_n_i = 1'b0;
    logic             wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]       wbs_sel_i = 4'hF;
    logic [31:0]      wbs_adr_i = '0, wbs_dat_i = '0;
    logic             wbs_ack_o;
    logic [31:0]      wbs_dat_o;
    logic [N-1:0]     s_cyc_o, s_stb_o;
    logic [N-1:0]     s_ack_i = '0;
    logic [32*N-1:0]  s_dat_i = '0;
    logic [7:0]       timeout_cnt_o;

    int n_chk = 0;
    int n_pass = 0;
    int exp_tcnt = 0;

    wb_slave_mux #(.N_SLAVES(N), .SEL_LSB(14), .SEL_W(3), .TIMEOUT(T), .DEFAULT_DATA(DEF)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .timeout_cnt_o(timeout_cnt_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One transfer: lat = edge (after the request edge) at which the selected slave acks,
    // ab = edge at which the master has dropped cyc. Outcome is whichever event comes first.
    task automatic run_txn(input logic [31:0] adr, input int lat, input int ab,
                           input logic [31:0] sdat, input bit noise);
        int           idx, fin, kind;  // kind: 0 abort, 1 ack, 2 timeout
        bit           mapped, cyc;
        logic [N-1:0] oh, nz;
        logic [31:0]  exp_dat;
        idx     = int'((adr >> 14) & 32'h7);
        mapped  = idx < N;
        oh      = mapped ? (N'(1) << idx) : '0;
        exp_dat = DEF;
        for (int k = 0; k < N; k++) s_dat_i[32*k +: 32] = (k == idx) ? sdat : $urandom;
        if (!mapped) begin
            kind = 1; fin = 0;
        end else if (ab <= lat && (!TO_EN || ab <= T)) begin
            kind = 0; fin = ab;
        end else if (!TO_EN || lat <= T) begin
            kind = 1; fin = lat; exp_dat = sdat;
        end else begin
            kind = 2; fin = T;
        end
        @(negedge wb_clk_i);
        wbs_adr_i = adr; wbs_we_i = $urandom; wbs_dat_i = $urandom;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        for (int j = 0; j <= fin + 1; j++) begin
            @(negedge wb_clk_i);
            chk("stb", 32'(s_stb_o), 32'((mapped && j < fin) ? oh : '0));
            chk("cyc", 32'(s_cyc_o), 32'((mapped && j < fin) ? oh : '0));
            chk("ack", 32'(wbs_ack_o), 32'(kind != 0 && j == fin));
            if (kind != 0 && j == fin) begin
                chk("dat", wbs_dat_o, exp_dat);
                if (kind == 2 && exp_tcnt < 255) exp_tcnt++;
            end
            cyc = (j + 1 < ab) && (j + 1 <= fin);
            wbs_cyc_i = cyc; wbs_stb_i = cyc;
            nz = noise ? N'($urandom) : '0;
            s_ack_i = (nz & ~oh) | ((mapped && j + 1 == lat) ? oh : '0);
        end
        s_ack_i = '0;
        chk("tcnt", 32'(timeout_cnt_o), 32'(exp_tcnt));
    endtask

    task automatic reset_mid();
        @(negedge wb_clk_i);
        wbs_adr_i = 32'h0000_4000; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("rst_pre_stb", 32'(s_stb_o), 32'h2);
        wb_rst_n_i = 1'b0;
        @(negedge wb_clk_i);
        exp_tcnt = 0;
        chk("rst_stb", 32'(s_stb_o), 32'h0);
        chk("rst_cyc", 32'(s_cyc_o), 32'h0);
        chk("rst_ack", 32'(wbs_ack_o), 32'h0);
        chk("rst_dat", wbs_dat_o, 32'h0);
        chk("rst_tcnt", 32'(timeout_cnt_o), 32'h0);
        wb_rst_n_i = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; s_ack_i = 4'b0010;
        for (int j = 0; j < 3; j++) begin
            @(negedge wb_clk_i);
            chk("post_rst_ack", 32'(wbs_ack_o), 32'h0);
            chk("post_rst_stb", 32'(s_stb_o), 32'h0);
        end
        s_ack_i = '0;
    endtask

    initial begin
        int idx, lat, ab;
        logic [31:0] adr;
        repeat (2) @(negedge wb_clk_i);
        chk("reset_ack", 32'(wbs_ack_o), 32'h0);
        chk("reset_dat", wbs_dat_o, 32'h0);
        chk("reset_stb", 32'(s_stb_o), 32'h0);
        chk("reset_tcnt", 32'(timeout_cnt_o), 32'h0);
        wb_rst_n_i = 1'b1;

        run_txn(32'h0000_8000, 3, NEVER, 32'h1234_5678, 1'b0);   // slave 2 read
        run_txn(32'h0001_C000, NEVER, NEVER, 32'h0, 1'b0);       // unmapped idx 7
        run_txn(32'h0000_0000, 2, 2, 32'hA5A5_A5A5, 1'b0);       // abort beats ack
        run_txn(32'h0000_C004, 1, NEVER, 32'h0BAD_F00D, 1'b1);   // zero-wait slave 3
        run_txn(32'h0000_4000, T, NEVER, 32'hCAFE_0001, 1'b0);   // ack on watchdog edge
        reset_mid();
        run_txn(32'h0000_4010, 1000, NEVER, 32'h5555_AAAA, 1'b0); // slow slave

        for (int i = 0; i < 150; i++) begin
            idx = $urandom_range(7);
            adr = ($urandom & ~32'h0001_C000) | (32'(idx) << 14);
            lat = $urandom_range(10, 1);
            ab  = ($urandom_range(1) == 0) ? NEVER : $urandom_range(12, 1);
            run_txn(adr, lat, ab, $urandom, 1'b1);
        end

`ifdef WB_MUX_TIMEOUT_EN
        for (int i = 0; i < 258; i++) run_txn(32'h0000_8000, NEVER, NEVER, 32'h0, 1'b0);
        chk("tcnt_sat", 32'(timeout_cnt_o), 32'd255);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/wb_slave_mux.md
# wb_slave_mux

Parametrised Wishbone classic slave-side multiplexer placed between the Caravel management Wishbone port and N user-area peripherals (CAN, DAC, FPGA bitstream loader, …). It generalises the fixed two-way, address-bit-14 split into an N-way decode on a configurable address field. Every transfer is registered through a small FSM, every request is guaranteed to terminate, and unmapped or hung accesses return a fixed default word.

## Interface
- N_SLAVES, 4: number of attached slaves, 2..8.
- SEL_LSB, 14: lowest address bit of the slave-select field.
- SEL_W, 3: width of the select field; indices ≥ N_SLAVES are unmapped.
- TIMEOUT, 255: max wait cycles for a slave ack, 1..255.
- DEFAULT_DATA, 32'hDEADBEEF: read data returned on unmapped, timed-out or aborted-by-timeout accesses.

Ports:
- wb_clk_i  in  1  sole clock; all logic on rising edge.
- wb_rst_n_i  in  1  reset, synchronous, active-low.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  master cycle/strobe/write.
- wbs_sel_i  in  4  byte selects (forwarded externally, unused here).
- wbs_adr_i  in  32  address; bits [SEL_LSB+SEL_W-1:SEL_LSB] select slave.
- wbs_dat_i  in  32  write data (forwarded externally, unused here).
- wbs_ack_o  out  1  registered ack to master.
- wbs_dat_o  out  32  registered read data.
- s_cyc_o, s_stb_o  out  N_SLAVES  per-slave cycle/strobe, one-hot or zero.
- s_ack_i  in  N_SLAVES  per-slave ack.
- s_dat_i  in  32*N_SLAVES  per-slave read data, slave k at [32k+31:32k].
- timeout_cnt_o  out  8  saturating count of timed-out transfers.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: on wbs_cyc_i & wbs_stb_i, latch index idx_q from address field.
  - idx_q < N_SLAVES: go BUSY, assert s_cyc_o[idx_q], s_stb_o[idx_q]; clear wait counter.
  - idx_q ≥ N_SLAVES: go RESP, load wbs_dat_o ← DEFAULT_DATA.
- BUSY: hold strobe; wait counter increments each cycle.
  - s_ack_i[idx_q]: capture s_dat_i slice into wbs_dat_o, drop strobe, go RESP.
  - wbs_cyc_i low (master abort): drop strobe, go IDLE, no ack.
  - counter reaches TIMEOUT (timeout feature only): drop strobe, wbs_dat_o ← DEFAULT_DATA, timeout_cnt_o += 1 (saturates at 255), go RESP.
  - Ack and timeout on the same cycle: ack wins, slave data returned, no count.
  - Ack and abort on the same cycle: abort wins.
- RESP: wbs_ack_o = 1 for exactly one cycle, then IDLE. A request still present in IDLE is treated as new.
- s_ack_i from a non-selected slave or outside BUSY is ignored.
- Writes return ack identically; wbs_dat_o is still loaded but don't-care.

## Timing
- Reset (wb_rst_n_i low at a rising edge): state IDLE; wbs_ack_o=0, wbs_dat_o=0, s_cyc_o=0, s_stb_o=0, timeout_cnt_o=0, idx_q=0. This applies mid-transfer: strobe drops and no ack is issued.
- Request sampled at edge E0 → slave strobe high from E0.
- Slave ack sampled at Ek → wbs_ack_o high during Ek..Ek+1 only.
- Zero-wait slave (acks at E1): master sees ack after 2 edges.
- Unmapped access: ack during E0..E1.
- Timeout: ack issued during the cycle after the TIMEOUT-th BUSY cycle.
- Minimum one IDLE cycle between consecutive acks.

## Configuration
- WB_MUX_TIMEOUT_EN defined: watchdog and timeout_cnt_o are active as described.
- WB_MUX_TIMEOUT_EN undefined: no counter. BUSY waits indefinitely for an ack or an abort, and timeout_cnt_o is tied to 0.

## Test plan
- Read from slave 2 (adr=32'h0000_8000), slave acks 3 cycles later with 32'h1234_5678 → s_stb_o=4'b0100 while BUSY; wbs_ack_o pulses one cycle; wbs_dat_o=32'h1234_5678.
- Access to adr=32'h0001_C000 (idx 7, N_SLAVES=4) → no s_stb_o, ack after 1 cycle, data 32'hDEADBEEF.
- Slave never acks, TIMEOUT=255, macro on → ack after 256 cycles, data 32'hDEADBEEF, timeout_cnt_o=1. Repeat 300 times → timeout_cnt_o=255.
- Master drops wbs_cyc_i in the 2nd BUSY cycle while slave 0 acks the same cycle → no wbs_ack_o, back to IDLE, strobe low.
- wb_rst_n_i low during BUSY → next cycle all outputs 0. A subsequent slave ack produces no wbs_ack_o.
- Macro off, slave acks after 1000 cycles → single ack with slave data; timeout_cnt_o stays 0.
